master_return_buffer: RTL and testbench

- Master-side return stage directly downstream of the backward arbiter for one master port.
- Takes the arbiter's granted slave number and pops one entry from that slave's return FIFO when it is valid for this master. Writes the entry into a local first-word-fall-through buffer.
- Presents buffered responses to the master with a valid/ready handshake.
- Drives master_fifo_full back to the arbiter, which freezes its priority rotation while full.

---
 rtl/master_return_buffer.sv | 60 ++++++
 tb/tb_master_return_buffer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/master_return_buffer.sv
// master_return_buffer: per-master FWFT return buffer fed from the granted slave FIFO
module master_return_buffer #(
    parameter int masters            = 2,
    parameter int slaves             = 2,
    parameter int i_am_master_number = 0,
    parameter int data_width         = 32,
    parameter int depth              = 4,
    localparam int mw                = masters > 1 ? $clog2(masters) : 1,
    localparam int sw                = slaves > 1 ? $clog2(slaves) : 1,
    localparam int aw                = $clog2(depth)
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [sw-1:0]                       grant_slave_number,
    input  logic [slaves-1:0]                   slave_fifo_empty,
    input  logic [slaves-1:0][mw-1:0]           slave_master_dest,
    input  logic [slaves-1:0][data_width-1:0]   slave_fifo_data,
    output logic [slaves-1:0]                   slave_fifo_pop,
    output logic                                master_fifo_full,
    output logic [data_width-1:0]               rdata,
    output logic                                rvalid,
    input  logic                                rready,
    output logic [aw:0]                         count
);
    logic [data_width-1:0] mem [depth];
    logic [aw-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop_out;

    assign master_fifo_full = count == (aw+1)'(depth);
    assign rvalid           = count != '0;
    assign rdata            = mem[rd_ptr];
    assign pop_out          = rvalid & rready;
    assign push             = ~ARESET & ~slave_fifo_empty[grant_slave_number]
                            & (slave_master_dest[grant_slave_number] == mw'(i_am_master_number))
                            & ~master_fifo_full;

    // one-hot pop strobe back to the granted slave, only when the grant is usable here
    always_comb begin
        slave_fifo_pop = '0;
        slave_fifo_pop[grant_slave_number] = push;
    end

    // storage write; contents need no reset since count gates visibility
    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= slave_fifo_data[grant_slave_number];
    end

    // pointers wrap naturally at depth (power of two); count tracks occupancy
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_out) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (aw+1)'(push) - (aw+1)'(pop_out);
        end
    end
endmodule

// File: tb/tb_master_return_buffer.sv
// tb_master_return_buffer: directed plus random checks against a queue model
module tb_master_return_buffer;
    logic             ACLK = 0;
    logic             ARESET;
    logic [0:0]       g;
    logic [1:0]       empty;
    logic [1:0][0:0]  dest;
    logic [1:0][31:0] data;
    logic [1:0]       pop;
    logic             full, rvalid, rready;
    logic [31:0]      rdata;
    logic [2:0]       count;
    logic [31:0]      q[$];
    int               errors = 0, checks = 0;

    master_return_buffer dut (
        .ACLK(ACLK), .ARESET(ARESET), .grant_slave_number(g),
        .slave_fifo_empty(empty), .slave_master_dest(dest), .slave_fifo_data(data),
        .slave_fifo_pop(pop), .master_fifo_full(full), .rdata(rdata),
        .rvalid(rvalid), .rready(rready), .count(count)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit will_push();
        return !ARESET && !empty[g] && dest[g] == 1'b0 && q.size() < 4;
    endfunction

    // check outputs against the queue model, then advance one clock
    task automatic cyc();
        bit push_e;
        int n;
        #1;
        n = q.size();
        push_e = will_push();
        check("pop", pop, push_e ? (2'b01 << g) : 2'b00);
        check("count", count, n);
        check("rvalid", rvalid, n != 0);
        check("full", full, n == 4);
        if (n != 0) check("rdata", rdata, q[0]);
        @(posedge ACLK);
        if (ARESET) q.delete();
        else begin
            if (rready && n != 0) void'(q.pop_front());
            if (push_e) q.push_back(data[g]);
        end
        @(negedge ACLK);
    endtask

    initial begin
        ARESET = 1; g = 0; empty = 2'b00; dest = '0; data = '0; rready = 0;
        @(posedge ACLK);
        @(negedge ACLK);
        // reset then idle with offered data
        repeat (3) cyc();
        // single transfer from slave 1
        ARESET = 0; g = 1; empty = 2'b01; data[1] = 32'hA5A5_0001;
        cyc();
        empty = 2'b11;
        cyc();
        check("single_rdata", rdata, 32'hA5A5_0001);
        rready = 1;
        cyc();
        rready = 0;
        // fill to full from slave 0
        g = 0; empty = 2'b00;
        repeat (6) begin
            data[0] = 32'h10 + q.size();
            cyc();
        end
        check("full_reached", full, 1'b1);
        rready = 1;
        cyc();
        check("after_pop_rdata", rdata, 32'h11);
        rready = 0; data[0] = 32'h14;
        cyc();
        check("resume_count", count, 3'd4);
        rready = 1; empty = 2'b11;
        repeat (5) cyc();
        rready = 0;
        // wrong destination, then empty slave
        g = 0; empty = 2'b00; dest[0] = 1'b1;
        repeat (2) cyc();
        g = 1; empty = 2'b10; dest = '0;
        repeat (2) cyc();
        check("no_push_rvalid", rvalid, 1'b0);
        // streaming with wrap
        begin
            int nxt = 0;
            g = 0; empty = 2'b00; rready = 1;
            while (nxt < 12) begin
                data[0] = nxt;
                if (will_push()) nxt++;
                cyc();
                check("stream_le1", count <= 3'd1, 1'b1);
            end
            empty = 2'b11;
            repeat (2) cyc();
        end
        // reset with three buffered entries
        rready = 0; empty = 2'b00;
        repeat (3) begin
            data[0] = 32'h30 + q.size();
            cyc();
        end
        check("pre_reset_count", count, 3'd3);
        ARESET = 1;
        cyc();
        ARESET = 0; data[0] = 32'h77;
        cyc();
        empty = 2'b11;
        cyc();
        check("post_reset_rdata", rdata, 32'h77);
        // random traffic
        repeat (400) begin
            ARESET = ($urandom_range(0, 49) == 0);
            g = $urandom_range(0, 1);
            empty = $urandom_range(0, 3);
            dest = $urandom_range(0, 3);
            data[0] = $urandom;
            data[1] = $urandom;
            rready = $urandom_range(0, 1);
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
